gate_truth_table_checker: RTL

//   On-chip stimulus/response checker for a 2-input combinational gate (and_gate, or_gate, ...).

---
 rtl/gate_truth_table_checker_if.sv | 39 +++
 rtl/gate_truth_table_checker.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_checker_if.sv
// Connection bundle between the truth-table checker and its surroundings:
// the gate-under-test pins plus the start/status signals seen by the host.
interface gate_truth_table_checker_if;
    logic       start;
    logic       gate_a;
    logic       gate_b;
    logic       gate_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] mismatch;
    logic [1:0] fail_index;

    // Checker side: drives the gate inputs and reports status
    modport master (
        input  start,
        input  gate_out,
        output gate_a,
        output gate_b,
        output busy,
        output done,
        output pass,
        output mismatch,
        output fail_index
    );

    // Host/gate side: requests runs, returns the gate output, reads results
    modport slave (
        output start,
        output gate_out,
        input  gate_a,
        input  gate_b,
        input  busy,
        input  done,
        input  pass,
        input  mismatch,
        input  fail_index
    );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Self-test engine for a 2-input gate: applies the four input vectors in order,
// lets each settle, samples the gate output and records any deviation from EXPECTED.
module gate_truth_table_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  EXPECTED      = 4'b1000,
    parameter bit          STOP_ON_FAIL  = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    gate_truth_table_checker_if.master     bus
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t           state_q,      state_d;
    logic [1:0]       idx_q,        idx_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [1:0]       gate_q,       gate_d;
    logic             done_q,       done_d;
    logic             pass_q,       pass_d;
    logic [3:0]       mismatch_q,   mismatch_d;
    logic [1:0]       fail_index_q, fail_index_d;

    logic             sample_bad;
    logic [3:0]       mismatch_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            gate_q       <= 2'b00;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            mismatch_q   <= 4'b0000;
            fail_index_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            gate_q       <= gate_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            mismatch_q   <= mismatch_d;
            fail_index_q <= fail_index_d;
        end
    end

    // The gate inputs are loaded on the edge that enters APPLY, so a vector
    // stays on the pins for the whole APPLY..SAMPLE window of that vector.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        gate_d        = gate_q;
        done_d        = done_q;
        pass_d        = pass_q;
        mismatch_d    = mismatch_q;
        fail_index_d  = fail_index_q;
        sample_bad    = 1'b0;
        mismatch_next = mismatch_q;

        case (state_q)
            ST_IDLE: begin
                gate_d = 2'b00;
                if (bus.start) begin
                    state_d      = ST_APPLY;
                    idx_d        = 2'd0;
                    mismatch_d   = 4'b0000;
                    fail_index_d = 2'd0;
                end
            end

            ST_APPLY: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SAMPLE: begin
                sample_bad = (bus.gate_out != EXPECTED[idx_q]);
                if (sample_bad) begin
                    mismatch_next[idx_q] = 1'b1;
                    if (mismatch_q == 4'b0000) begin
                        fail_index_d = idx_q;
                    end
                end
                mismatch_d = mismatch_next;

                if ((sample_bad && STOP_ON_FAIL) || (idx_q == 2'd3)) begin
                    state_d = ST_DONE;
                    gate_d  = 2'b00;
                    done_d  = 1'b1;
                    pass_d  = (mismatch_next == 4'b0000);
                end else begin
                    state_d = ST_APPLY;
                    idx_d   = idx_q + 2'd1;
                    gate_d  = idx_q + 2'd1;
                end
            end

            ST_DONE: begin
                gate_d = 2'b00;
                if (bus.start) begin
                    state_d      = ST_APPLY;
                    idx_d        = 2'd0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    mismatch_d   = 4'b0000;
                    fail_index_d = 2'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gate_d  = 2'b00;
            end
        endcase
    end

    assign bus.gate_a     = gate_q[1];
    assign bus.gate_b     = gate_q[0];
    assign bus.busy       = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                            (state_q == ST_SAMPLE);
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.fail_index = fail_index_q;

endmodule
